// File: rtl/pe_ipad_ctl_pkg.sv
// Shared types, encodings and helpers for the PE input-pixel scratchpad controller.
package pe_ipad_ctl_pkg;

    localparam int unsigned IPadSize = 12;
    localparam int unsigned AddrWd   = $clog2(IPadSize);
    localparam int unsigned CfgWd    = 6;
    localparam int unsigned TwWd     = 10;
    localparam int unsigned ProdWd   = 12;
    localparam int unsigned IssWd    = 3;
    localparam int unsigned StateWd  = 4;

    localparam logic [AddrWd:0] PadSz = (AddrWd+1)'(IPadSize);

    // PEiss instruction encoding
    localparam logic [IssWd-1:0] ISS_STALL = 3'd0;
    localparam logic [IssWd-1:0] ISS_RESET = 3'd1;
    localparam logic [IssWd-1:0] ISS_START = 3'd2;
    localparam logic [IssWd-1:0] ISS_WORK  = 3'd3;

    // IPadState encoding
    localparam logic [StateWd-1:0] ST_IDLE = 4'd0;
    localparam logic [StateWd-1:0] ST_INIT = 4'd1;
    localparam logic [StateWd-1:0] ST_LOOP = 4'd2;
    localparam logic [StateWd-1:0] ST_POP  = 4'd3;
    localparam logic [StateWd-1:0] ST_OLAP = 4'd4;

    typedef struct packed {
        logic [AddrWd-1:0] raddr;
        logic [AddrWd-1:0] waddr;
        logic              read;
        logic              write;
    } ipad_addr_t;

    typedef struct packed {
        logic [CfgWd-1:0] pch;
        logic [CfgWd-1:0] r;
        logic [CfgWd-1:0] u;
        logic [TwWd-1:0]  tw;
    } ipad_ctl_cfg_t;

    // Modular add for n <= size; one conditional subtract is enough.
    function automatic logic [AddrWd-1:0] ptr_add(input logic [AddrWd-1:0] p,
                                                  input logic [AddrWd-1:0] n,
                                                  input logic [AddrWd:0]   size);
        logic [AddrWd:0] sum;
        sum = {1'b0, p} + {1'b0, n};
        if (sum >= size) begin
            sum = sum - size;
        end
        return sum[AddrWd-1:0];
    endfunction

    function automatic logic cfg_legal(input ipad_ctl_cfg_t c);
        logic [ProdWd-1:0] win;
        win = ProdWd'(c.pch) * ProdWd'(c.r);
        return (c.pch != '0) && (c.r != '0) && (c.u != '0) && (c.tw != '0)
            && (win <= ProdWd'(IPadSize)) && (c.u <= c.r);
    endfunction

endpackage

// File: rtl/pe_ipad_ctl.sv
// IPad sequencer: fills, reads and slides a circular Pch*R pixel window by Pch*U per step.
module pe_ipad_ctl
    import pe_ipad_ctl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [IssWd-1:0]   iss,
    input  logic [CfgWd-1:0]   cfg_pch,
    input  logic [CfgWd-1:0]   cfg_r,
    input  logic [CfgWd-1:0]   cfg_u,
    input  logic [TwWd-1:0]    cfg_tw,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic               mac_ready,
    output ipad_addr_t         ipad,
    output logic               win_done,
    output logic               row_done,
    output logic               cfg_err,
    output logic [StateWd-1:0] state
);

    logic [StateWd-1:0] state_q, state_d;
    logic [AddrWd-1:0]  head_q, head_d;
    logic [AddrWd-1:0]  wptr_q, wptr_d;
    logic [AddrWd-1:0]  rcnt_q, rcnt_d;
    logic [AddrWd-1:0]  fcnt_q, fcnt_d;
    logic [TwWd-1:0]    wcnt_q, wcnt_d;
    logic [AddrWd-1:0]  win_q, win_d;
    logic [AddrWd-1:0]  step_q, step_d;
    logic [TwWd-1:0]    tw_q, tw_d;
    logic               fill_q, fill_d;
    logic               win_done_q, win_done_d;
    logic               row_done_q, row_done_d;
    logic               cfg_err_q, cfg_err_d;

    ipad_ctl_cfg_t     cfg_in;
    logic [ProdWd-1:0] win_prod;
    logic [ProdWd-1:0] step_prod;
    logic              is_work;
    logic              rd_c;
    logic              wr_c;
    logic [AddrWd-1:0] fill_tgt;

    assign cfg_in    = '{pch: cfg_pch, r: cfg_r, u: cfg_u, tw: cfg_tw};
    assign win_prod  = ProdWd'(cfg_pch) * ProdWd'(cfg_r);
    assign step_prod = ProdWd'(cfg_pch) * ProdWd'(cfg_u);

    // fill_q marks INIT/OLAP with entries still owed; the issue bus gates it same-cycle
    assign is_work   = (iss == ISS_WORK);
    assign pix_ready = fill_q & is_work;
    assign wr_c      = pix_valid & pix_ready;
    assign rd_c      = (state_q == ST_LOOP) & is_work & mac_ready;
    assign fill_tgt  = (state_q == ST_INIT) ? win_q : step_q;

    assign ipad.raddr = ptr_add(head_q, rcnt_q, PadSz);
    assign ipad.waddr = wptr_q;
    assign ipad.read  = rd_c;
    assign ipad.write = wr_c;

    assign win_done = win_done_q;
    assign row_done = row_done_q;
    assign cfg_err  = cfg_err_q;
    assign state    = state_q;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        wptr_d     = wptr_q;
        rcnt_d     = rcnt_q;
        fcnt_d     = fcnt_q;
        wcnt_d     = wcnt_q;
        win_d      = win_q;
        step_d     = step_q;
        tw_d       = tw_q;
        fill_d     = fill_q;
        cfg_err_d  = cfg_err_q;
        win_done_d = 1'b0;
        row_done_d = 1'b0;

        if (iss == ISS_RESET) begin
            state_d   = ST_IDLE;
            head_d    = '0;
            wptr_d    = '0;
            rcnt_d    = '0;
            fcnt_d    = '0;
            wcnt_d    = '0;
            win_d     = '0;
            step_d    = '0;
            tw_d      = '0;
            fill_d    = 1'b0;
            cfg_err_d = 1'b0;
        end else if (iss != ISS_STALL) begin
            case (state_q)
                ST_IDLE: begin
                    if (iss == ISS_START) begin
                        if (cfg_legal(cfg_in)) begin
                            state_d   = ST_INIT;
                            head_d    = '0;
                            wptr_d    = '0;
                            rcnt_d    = '0;
                            fcnt_d    = '0;
                            wcnt_d    = '0;
                            win_d     = AddrWd'(win_prod);
                            step_d    = AddrWd'(step_prod);
                            tw_d      = cfg_tw;
                            fill_d    = 1'b1;
                            cfg_err_d = 1'b0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_INIT, ST_OLAP: begin
                    if (wr_c) begin
                        wptr_d = ptr_add(wptr_q, AddrWd'(1), PadSz);
                        if (fcnt_q + AddrWd'(1) == fill_tgt) begin
                            fcnt_d  = '0;
                            fill_d  = 1'b0;
                            state_d = ST_LOOP;
                        end else begin
                            fcnt_d = fcnt_q + AddrWd'(1);
                        end
                    end
                end
                ST_LOOP: begin
                    if (rd_c) begin
                        if (rcnt_q == win_q - AddrWd'(1)) begin
                            rcnt_d     = '0;
                            wcnt_d     = wcnt_q + TwWd'(1);
                            win_done_d = 1'b1;
                            if (wcnt_q + TwWd'(1) == tw_q) begin
                                row_done_d = 1'b1;
                                state_d    = ST_IDLE;
                            end else begin
                                state_d = ST_POP;
                            end
                        end else begin
                            rcnt_d = rcnt_q + AddrWd'(1);
                        end
                    end
                end
                ST_POP: begin
                    // releasing the oldest step entries makes room for the overlap refill
                    if (is_work) begin
                        head_d  = ptr_add(head_q, step_q, PadSz);
                        fill_d  = 1'b1;
                        state_d = ST_OLAP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    fill_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            head_q     <= '0;
            wptr_q     <= '0;
            rcnt_q     <= '0;
            fcnt_q     <= '0;
            wcnt_q     <= '0;
            win_q      <= '0;
            step_q     <= '0;
            tw_q       <= '0;
            fill_q     <= 1'b0;
            win_done_q <= 1'b0;
            row_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            wptr_q     <= wptr_d;
            rcnt_q     <= rcnt_d;
            fcnt_q     <= fcnt_d;
            wcnt_q     <= wcnt_d;
            win_q      <= win_d;
            step_q     <= step_d;
            tw_q       <= tw_d;
            fill_q     <= fill_d;
            win_done_q <= win_done_d;
            row_done_q <= row_done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_pe_ipad_ctl.sv
// Randomized bench for pe_ipad_ctl against a window/fill counting model of the sliding pad.
module tb_pe_ipad_ctl;
    import pe_ipad_ctl_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [IssWd-1:0]   iss;
    logic [CfgWd-1:0]   cfg_pch, cfg_r, cfg_u;
    logic [TwWd-1:0]    cfg_tw;
    logic               pix_valid, pix_ready, mac_ready;
    ipad_addr_t         ipad;
    logic               win_done, row_done, cfg_err;
    logic [StateWd-1:0] state;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    pe_ipad_ctl dut (
        .clk(clk), .rst(rst), .iss(iss),
        .cfg_pch(cfg_pch), .cfg_r(cfg_r), .cfg_u(cfg_u), .cfg_tw(cfg_tw),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .mac_ready(mac_ready),
        .ipad(ipad), .win_done(win_done), .row_done(row_done),
        .cfg_err(cfg_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(ST_IDLE));
        chk({tag, "_ipad"}, 32'(ipad), 32'd0);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_win_done"}, 32'(win_done), 32'd0);
        chk({tag, "_row_done"}, 32'(row_done), 32'd0);
    endtask

    task automatic start_cfg(input int pch, input int r, input int u, input int tw);
        @(negedge clk);
        iss       = ISS_START;
        cfg_pch   = CfgWd'(pch);
        cfg_r     = CfgWd'(r);
        cfg_u     = CfgWd'(u);
        cfg_tw    = TwWd'(tw);
        pix_valid = 1'b1;
        mac_ready = 1'b1;
    endtask

    // Window k covers pixel stream indices k*step .. k*step+win-1, stored at index mod 12.
    task automatic run_row(input int pch, input int r, input int u, input int tw, input bit stalls);
        int  win, step, k, i, wr, need;
        bit  pop, pend_wd, pend_rw, exp_rdy, exp_rd, done;
        win  = pch * r;
        step = pch * u;
        k = 0; i = 0; wr = 0;
        pop = 0; pend_wd = 0; pend_rw = 0; done = 0;
        start_cfg(pch, r, u, tw);
        #1;
        chk("start_pix_ready", 32'(pix_ready), 32'd0);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            iss       = (stalls && $urandom_range(0, 5) == 0) ? ISS_STALL : ISS_WORK;
            pix_valid = ($urandom_range(0, 3) != 0);
            mac_ready = ($urandom_range(0, 3) != 0);
            #1;
            need    = k * step + win;
            exp_rdy = (iss == ISS_WORK) && !pop && (k < tw) && (wr < need);
            exp_rd  = (iss == ISS_WORK) && mac_ready && (k < tw) && (wr == need);
            chk("win_done", 32'(win_done), 32'(pend_wd));
            chk("row_done", 32'(row_done), 32'(pend_rw));
            chk("pix_ready", 32'(pix_ready), 32'(exp_rdy));
            chk("write", 32'(ipad.write), 32'(exp_rdy && pix_valid));
            chk("read", 32'(ipad.read), 32'(exp_rd));
            if (pend_rw) begin
                chk("row_end_state", 32'(state), 32'(ST_IDLE));
                done = 1;
            end
            pend_wd = 0;
            pend_rw = 0;
            if (pop && iss == ISS_WORK) pop = 0;
            if (ipad.write && exp_rdy) begin
                chk("waddr", 32'(ipad.waddr), 32'(wr % IPadSize));
                wr++;
            end
            if (ipad.read && exp_rd) begin
                chk("raddr", 32'(ipad.raddr), 32'((k * step + i) % IPadSize));
                i++;
                if (i == win) begin
                    i = 0;
                    k++;
                    pend_wd = 1;
                    pend_rw = (k == tw);
                    pop     = (k < tw);
                end
            end
        end
        if (!done) chk("row_timeout", 32'd0, 32'd1);
        @(negedge clk);
        iss = ISS_STALL;
    endtask

    task automatic wait_state(input logic [StateWd-1:0] st, input string tag);
        bit seen;
        seen = 0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            iss       = ISS_WORK;
            pix_valid = 1'b1;
            mac_ready = 1'b1;
            #1;
            seen = (state == st);
        end
        if (!seen) chk(tag, 32'(state), 32'(st));
    endtask

    initial begin
        int pch, r, u, tw, rmax;
        rst = 1'b1;
        iss = ISS_STALL;
        cfg_pch = '0; cfg_r = '0; cfg_u = '0; cfg_tw = '0;
        pix_valid = 1'b0;
        mac_ready = 1'b0;
        #1;
        chk_idle_outputs("reset");
        chk("reset_cfg_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // directed test-plan rows, then the wrap row under random stalls
        run_row(2, 3, 1, 1, 1'b0);
        run_row(2, 3, 1, 5, 1'b0);
        run_row(1, 4, 4, 3, 1'b0);
        run_row(2, 3, 1, 5, 1'b1);
        run_row(1, 12, 12, 2, 1'b1);
        run_row(6, 2, 2, 4, 1'b1);

        for (int n = 0; n < 6; n++) begin
            pch  = $urandom_range(1, 4);
            rmax = 12 / pch;
            if (rmax > 6) rmax = 6;
            r    = $urandom_range(1, rmax);
            u    = $urandom_range(1, r);
            tw   = $urandom_range(1, 6);
            run_row(pch, r, u, tw, 1'b1);
        end

        // illegal configs keep the controller idle and flag cfg_err
        start_cfg(4, 4, 1, 2);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            iss = ISS_WORK;
            pix_valid = 1'b1;
            #1;
            chk("ill_win_cfg_err", 32'(cfg_err), 32'd1);
            chk("ill_win_state", 32'(state), 32'(ST_IDLE));
            chk("ill_win_write", 32'(ipad.write), 32'd0);
        end
        start_cfg(1, 2, 3, 2);
        @(negedge clk);
        iss = ISS_WORK;
        #1;
        chk("ill_u_cfg_err", 32'(cfg_err), 32'd1);
        chk("ill_u_state", 32'(state), 32'(ST_IDLE));
        chk("ill_u_pix_ready", 32'(pix_ready), 32'd0);
        start_cfg(2, 3, 1, 0);
        @(negedge clk);
        iss = ISS_STALL;
        #1;
        chk("ill_tw_state", 32'(state), 32'(ST_IDLE));
        start_cfg(2, 3, 1, 2);
        @(negedge clk);
        iss = ISS_STALL;
        #1;
        chk("legal_clears_cfg_err", 32'(cfg_err), 32'd0);
        chk("legal_state_init", 32'(state), 32'(ST_INIT));
        chk("stall_pix_ready", 32'(pix_ready), 32'd0);

        // instruction-level RESET from OLAP
        iss = ISS_RESET;
        @(negedge clk);
        iss = ISS_STALL;
        #1;
        chk_idle_outputs("iss_reset_init");
        start_cfg(2, 3, 1, 5);
        wait_state(ST_OLAP, "reach_olap");
        iss = ISS_RESET;
        @(negedge clk);
        iss = ISS_STALL;
        #1;
        chk_idle_outputs("iss_reset_olap");
        chk("iss_reset_cfg_err", 32'(cfg_err), 32'd0);

        // asynchronous rst in LOOP clears outputs without a clock edge
        start_cfg(2, 3, 1, 5);
        wait_state(ST_LOOP, "reach_loop");
        @(negedge clk);
        iss = ISS_WORK;
        mac_ready = 1'b1;
        #1;
        chk("loop_read_before_rst", 32'(ipad.read), 32'd1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        chk("async_rst_cfg_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        iss = ISS_STALL;
        run_row(2, 3, 1, 2, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
